// File: rtl/sisp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sisp_pkg
// Brief    : Shared widths, FSM state type and key comparison for the
//            SISP top-K streaming sorter.
// Revision : 1.0 - initial release
// ============================================================================
package sisp_pkg;

  localparam int SISP_W     = 14;
  localparam int SISP_KEY_W = 9;
  localparam int SISP_DEPTH = 8;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } sisp_state_e;

  // Signed strict greater-than on the key field only; tag bits never reach here.
  function automatic logic key_gt(input logic [SISP_KEY_W-1:0] a,
                                  input logic [SISP_KEY_W-1:0] b);
    return $signed(a) > $signed(b);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sisp_topk_sorter_if.sv
`default_nettype none
// ============================================================================
// Module   : sisp_topk_sorter_if
// Brief    : Input/output streaming handshake bundle of the top-K sorter.
//            master = traffic source/sink side, slave = sorter side.
// Revision : 1.0 - initial release
// ============================================================================
interface sisp_topk_sorter_if
  import sisp_pkg::*;
#(
  parameter int W = SISP_W
);

  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_last;
  logic         out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

endinterface
`default_nettype wire

// File: rtl/sisp_sort_cell.sv
`default_nettype none
// ============================================================================
// Module   : sisp_sort_cell
// Brief    : One slot of the insertion sorter: a word plus an empty flag.
//            Loads the new word, the word above (insert shift) or the word
//            below (drain shift), and tells the priority logic whether the
//            new word belongs at or above this slot.
// Revision : 1.0 - initial release
// ============================================================================
module sisp_sort_cell
  import sisp_pkg::*;
#(
  parameter int W     = SISP_W,
  parameter int KEY_W = SISP_KEY_W
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic [W-1:0] new_word_i,
  input  wire logic         ins_i,
  input  wire logic         fill_i,
  input  wire logic         drain_i,
  input  wire logic [W-1:0] above_word_i,
  input  wire logic         above_empty_i,
  input  wire logic [W-1:0] below_word_i,
  input  wire logic         below_empty_i,
  output logic [W-1:0]      word_o,
  output logic              empty_o,
  output logic              gt_o
);

  logic [W-1:0] word_q;
  logic         empty_q;

  // Slot storage: insert has priority over the fill shift; drain never
  // coincides with either because they belong to different FSM states.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q  <= '0;
      empty_q <= 1'b1;
    end else if (ins_i) begin
      word_q  <= new_word_i;
      empty_q <= 1'b0;
    end else if (fill_i) begin
      word_q  <= above_word_i;
      empty_q <= above_empty_i;
    end else if (drain_i) begin
      word_q  <= below_word_i;
      empty_q <= below_empty_i;
    end
  end

  assign word_o  = word_q;
  assign empty_o = empty_q;
  // Equal keys are not "greater", so later arrivals land after earlier ones.
  assign gt_o    = empty_q | key_gt(new_word_i[KEY_W-1:0], word_q[KEY_W-1:0]);

endmodule
`default_nettype wire

// File: rtl/sisp_topk_sorter.sv
`default_nettype none
// ============================================================================
// Module   : sisp_topk_sorter
// Brief    : Streaming insertion sorter keeping the DEPTH largest words of a
//            frame by signed key, drained in descending key order on frame end.
// Revision : 1.0 - initial release
// ============================================================================
module sisp_topk_sorter
  import sisp_pkg::*;
#(
  parameter int W     = SISP_W,
  parameter int KEY_W = SISP_KEY_W,
  parameter int DEPTH = SISP_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  wire logic          clk,
  input  wire logic          rst,
  sisp_topk_sorter_if.slave  bus,
  output logic [CW-1:0]      count,
  output logic               overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  sisp_state_e     state_q;
  logic [CW-1:0]   count_q;
  logic            overflow_q;

  logic [W-1:0]    w_word [DEPTH];
  logic [DEPTH-1:0] w_empty;
  logic [DEPTH-1:0] w_gt;
  logic [DEPTH-1:0] w_ins;
  logic [DEPTH-1:0] w_fill;
  logic            w_accept;
  logic            w_pop;
  logic            w_found;
  logic [PW-1:0]   w_pos;

  assign w_accept = bus.in_valid & bus.in_ready;
  assign w_pop    = bus.out_valid & bus.out_ready;

  // Priority encoder: lowest-index slot that is empty or holds a smaller key.
  always_comb begin
    w_found = 1'b0;
    w_pos   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_gt[i]) begin
        w_found = 1'b1;
        w_pos   = PW'(i);
      end
    end
  end

  // Per-slot controls: write at the insert point, shift everything below it.
  always_comb begin
    w_ins  = '0;
    w_fill = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_ins[i]  = w_accept & w_found & (PW'(i) == w_pos);
      w_fill[i] = w_accept & w_found & (PW'(i) >  w_pos);
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [W-1:0] w_above_word;
    logic         w_above_empty;
    logic [W-1:0] w_below_word;
    logic         w_below_empty;

    if (i == 0) begin : g_head
      assign w_above_word  = '0;
      assign w_above_empty = 1'b1;
    end else begin : g_chain_up
      assign w_above_word  = w_word[i-1];
      assign w_above_empty = w_empty[i-1];
    end

    if (i == DEPTH - 1) begin : g_tail
      assign w_below_word  = '0;
      assign w_below_empty = 1'b1;
    end else begin : g_chain_dn
      assign w_below_word  = w_word[i+1];
      assign w_below_empty = w_empty[i+1];
    end

    sisp_sort_cell #(
      .W     (W),
      .KEY_W (KEY_W)
    ) u_cell (
      .clk           (clk),
      .rst           (rst),
      .new_word_i    (bus.in_data),
      .ins_i         (w_ins[i]),
      .fill_i        (w_fill[i]),
      .drain_i       (w_pop),
      .above_word_i  (w_above_word),
      .above_empty_i (w_above_empty),
      .below_word_i  (w_below_word),
      .below_empty_i (w_below_empty),
      .word_o        (w_word[i]),
      .empty_o       (w_empty[i]),
      .gt_o          (w_gt[i])
    );
  end

  // Frame FSM with occupancy count and sticky per-frame overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (w_accept) begin
            if (count_q != CW'(DEPTH)) begin
              count_q <= count_q + 1'b1;
            end else begin
              overflow_q <= 1'b1;
            end
            if (bus.in_last) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_pop) begin
            count_q <= count_q - 1'b1;
            if (count_q == CW'(1)) begin
              state_q    <= FILL;
              overflow_q <= 1'b0;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  // Outputs come straight from state; in_ready is masked while in reset.
  assign bus.in_ready  = (state_q == FILL) & ~rst;
  assign bus.out_valid = (state_q == DRAIN) & (count_q != '0);
  assign bus.out_last  = (state_q == DRAIN) & (count_q == CW'(1));
  assign bus.out_data  = w_word[0];
  assign count         = count_q;
  assign overflow      = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sisp_topk_sorter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sisp_topk_sorter
// Brief    : Self-checking bench for the top-K sorter. Expected drain order
//            comes from a stable selection of the largest keys of each frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sisp_topk_sorter;

  localparam int W     = 14;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst;
  logic [CW-1:0] count;
  logic          overflow;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] frame_q [$];
  logic [W-1:0] exp_q   [$];

  sisp_topk_sorter_if #(.W(W)) bus ();

  sisp_topk_sorter #(.DEPTH(DEPTH)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .count    (count),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int key_of(input logic [W-1:0] w);
    logic signed [8:0] k;
    k = w[8:0];
    return int'(k);
  endfunction

  // Reference: pick the largest key repeatedly, earliest arrival wins ties.
  task automatic build_expect();
    bit used [64];
    int n;
    int take;
    n    = frame_q.size();
    take = (n < DEPTH) ? n : DEPTH;
    exp_q.delete();
    for (int j = 0; j < 64; j++) used[j] = 1'b0;
    for (int k = 0; k < take; k++) begin
      int best;
      best = -1;
      for (int j = 0; j < n; j++) begin
        if (!used[j] && (best < 0 || key_of(frame_q[j]) > key_of(frame_q[best])))
          best = j;
      end
      used[best] = 1'b1;
      exp_q.push_back(frame_q[best]);
    end
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_last", 32'(bus.out_last), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("post_rst_out_data", 32'(bus.out_data), 32'd0);
    check_eq("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic send_frame(input bit gaps);
    int n;
    n = frame_q.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (gaps) begin
        int idle;
        idle = $urandom_range(0, 2);
        for (int g = 0; g < idle; g++) begin
          bus.in_valid = 1'b0;
          @(negedge clk);
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = frame_q[k];
      bus.in_last  = (k == n - 1);
      check_eq("fill_in_ready", 32'(bus.in_ready), 32'd1);
      check_eq("fill_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("fill_count", 32'(count), 32'((k < DEPTH) ? k : DEPTH));
      check_eq("fill_overflow", 32'(overflow), 32'(k > DEPTH));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check_eq("drain_entry_valid", 32'(bus.out_valid), 32'd1);
    check_eq("drain_entry_last", 32'(bus.out_last), 32'(exp_q.size() == 1));
    check_eq("drain_entry_in_ready", 32'(bus.in_ready), 32'd0);
  endtask

  // bp_mode: 0 always ready, 1 random, 2 repeating 1,0,0,1.
  // abort_left >= 0 stops (without post checks) once that many entries remain.
  task automatic drain(input bit ovf, input int bp_mode, input bit hammer, input int abort_left);
    int  k;
    int  n;
    int  cyc;
    bit  rdy;
    bit  aborted;
    k = 0;
    n = exp_q.size();
    cyc = 0;
    aborted = 1'b0;
    while (k < n && cyc < 400) begin
      @(negedge clk);
      if (abort_left >= 0 && (n - k) == abort_left) begin
        aborted = 1'b1;
        break;
      end
      case (bp_mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 1) == 1);
        default: rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      endcase
      bus.out_ready = rdy;
      if (hammer) begin
        bus.in_valid = 1'b1;
        bus.in_data  = W'($urandom);
        bus.in_last  = ($urandom_range(0, 1) == 1);
      end
      check_eq("drain_valid", 32'(bus.out_valid), 32'd1);
      check_eq("drain_data", 32'(bus.out_data), 32'(exp_q[k]));
      check_eq("drain_last", 32'(bus.out_last), 32'(k == n - 1));
      check_eq("drain_count", 32'(count), 32'(n - k));
      check_eq("drain_overflow", 32'(overflow), 32'(ovf));
      check_eq("drain_in_ready", 32'(bus.in_ready), 32'd0);
      if (rdy) k++;
      cyc++;
    end
    if (cyc >= 400) check_eq("drain_timeout", 32'(k), 32'(n));
    if (aborted) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      check_eq("abort_count", 32'(count), 32'(abort_left));
    end else begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      check_eq("done_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("done_out_last", 32'(bus.out_last), 32'd0);
      check_eq("done_in_ready", 32'(bus.in_ready), 32'd1);
      check_eq("done_count", 32'(count), 32'd0);
      check_eq("done_overflow", 32'(overflow), 32'd0);
    end
  endtask

  task automatic run_frame(input bit gaps, input int bp_mode, input bit hammer, input int abort_left);
    build_expect();
    send_frame(gaps);
    drain(frame_q.size() > DEPTH, bp_mode, hammer, abort_left);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    do_reset();

    // Mixed signs: 5, -3, 100, 0
    frame_q = {14'd5, 14'h01FD, 14'd100, 14'd0};
    run_frame(1'b0, 0, 1'b0, -1);

    // Ascending 1..10 overflows an 8-deep sorter
    frame_q.delete();
    for (int i = 1; i <= 10; i++) frame_q.push_back(W'(i));
    run_frame(1'b0, 0, 1'b0, -1);

    // Equal keys keep arrival order; -256 is the most negative key
    frame_q = {14'h0E07, 14'h1007, 14'h0700};
    run_frame(1'b0, 0, 1'b0, -1);

    // Backpressure 1,0,0,1 while upstream keeps pushing during drain
    frame_q.delete();
    for (int i = 0; i < 6; i++) frame_q.push_back(W'($urandom));
    run_frame(1'b0, 2, 1'b1, -1);

    // Single-word frame with key -1
    frame_q = {14'h01FF};
    run_frame(1'b0, 0, 1'b0, -1);

    // Reset in the middle of a drain with three entries left
    frame_q.delete();
    for (int i = 1; i <= 10; i++) frame_q.push_back(W'(i));
    run_frame(1'b0, 0, 1'b0, 3);
    do_reset();
    frame_q = {14'd42, 14'h01F0, 14'd7};
    run_frame(1'b0, 0, 1'b0, -1);

    // Random frames: short and overflowing lengths, narrow key range for ties
    for (int f = 0; f < 24; f++) begin
      int len;
      len = $urandom_range(1, 14);
      frame_q.delete();
      for (int i = 0; i < len; i++) begin
        logic [4:0] tag;
        logic [8:0] key;
        tag = 5'($urandom);
        if ($urandom_range(0, 1) == 1) key = 9'($urandom_range(0, 15) - 8);
        else                           key = 9'($urandom);
        frame_q.push_back({tag, key});
      end
      run_frame(1'b1, 1, ($urandom_range(0, 1) == 1), -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
